// File: rtl/cache_victim_sel_pkg.sv
// Shared cache constants, index types and the LFSR tap table.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_victim_sel_pkg;

  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 16;
  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam int SET_BITS = $clog2(NUM_SETS);

  typedef logic [WAY_BITS-1:0] way_idx_t;
  typedef logic [SET_BITS-1:0] set_idx_t;

  // Maximal-length Fibonacci tap masks; bit (t-1) set for polynomial term x^t.
  function automatic logic [31:0] lfsr_taps(input int n);
    case (n)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/victim_lfsr.sv
// Free-running pseudorandom source for victim offsets; steps only when enabled.
// Latency: new value visible the cycle after enable.
// Backpressure: none; enable is the only throttle.
module victim_lfsr #(
  parameter int NUM_BITS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  output logic [NUM_BITS-1:0] lfsr
);
  import cache_victim_sel_pkg::*;

  localparam logic [31:0] TAPS = lfsr_taps(NUM_BITS);

  logic feedback;

  // XOR of the tapped bits; a nonzero seed never reaches the all-zero lock-up state.
  assign feedback = ^(lfsr & TAPS[NUM_BITS-1:0]);

  // Shift in the feedback bit on each enabled cycle; seed is 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= NUM_BITS'(1);
    end else if (enable) begin
      lfsr <= {lfsr[NUM_BITS-2:0], feedback};
    end
  end

endmodule

// File: rtl/cache_victim_sel.sv
// Victim way selector: lowest invalid way, else a non-MRU way chosen pseudorandomly.
// Latency: victim_valid strobes exactly one cycle after victim_req is accepted.
// Backpressure: victim_ready low from PICK until fill/cancel; requests then are ignored.
module cache_victim_sel #(
  parameter int NUM_WAYS  = cache_victim_sel_pkg::NUM_WAYS,
  parameter int NUM_SETS  = cache_victim_sel_pkg::NUM_SETS,
  parameter int LFSR_BITS = $clog2(NUM_WAYS) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        access_valid,
  input  logic [$clog2(NUM_SETS)-1:0] access_set,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  input  logic                        victim_req,
  input  logic [$clog2(NUM_SETS)-1:0] victim_set,
  output logic                        victim_ready,
  output logic                        victim_valid,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way,
  input  logic                        victim_cancel,
  input  logic                        fill_valid,
  input  logic                        inval_valid,
  input  logic [$clog2(NUM_SETS)-1:0] inval_set,
  input  logic [$clog2(NUM_WAYS)-1:0] inval_way,
  input  logic                        inval_all
);
  import cache_victim_sel_pkg::*;

  localparam int WB = $clog2(NUM_WAYS);
  localparam int SB = $clog2(NUM_SETS);

  typedef enum logic [1:0] {IDLE, PICK, WAIT_FILL} state_t;

  state_t                state_q, state_d;
  logic [SB-1:0]         pend_set;
  logic [WB-1:0]         pend_way;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [WB-1:0]         mru_q   [NUM_SETS];
  logic [LFSR_BITS-1:0]  lfsr;
  logic                  lfsr_en;
  logic                  fill_fire;
  logic [NUM_WAYS-1:0]   set_valid;
  logic [WB-1:0]         set_mru;
  logic [WB-1:0]         pick_off;
  logic [WB-1:0]         pick_way;
  logic                  lfsr_unused;

  generate
    if (NUM_WAYS > 2) begin : g_lfsr
      victim_lfsr #(.NUM_BITS(LFSR_BITS)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (lfsr_en),
        .lfsr   (lfsr)
      );
    end else begin : g_no_lfsr
      assign lfsr = LFSR_BITS'(1);
    end
  endgenerate

  // Only the low WB bits feed the offset; the rest of the LFSR is internal state.
  assign lfsr_unused = ^{lfsr, lfsr_en};

  // Victim choice for the pending set: lowest invalid way wins, otherwise avoid MRU.
  always_comb begin
    set_valid = valid_q[pend_set];
    set_mru   = mru_q[pend_set];
    pick_off  = lfsr[WB-1:0];
    if (pick_off == '0) pick_off = WB'(1);
    if (NUM_WAYS == 2) pick_way = ~set_mru;
    else               pick_way = set_mru + pick_off;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) pick_way = WB'(w);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and outputs; victim_way shows the held pend_way outside PICK.
  always_comb begin
    state_d      = state_q;
    victim_ready = 1'b0;
    victim_valid = 1'b0;
    victim_way   = pend_way;
    lfsr_en      = 1'b0;
    fill_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        victim_ready = 1'b1;
        if (victim_req) state_d = PICK;
      end
      PICK: begin
        victim_valid = 1'b1;
        victim_way   = pick_way;
        lfsr_en      = 1'b1;
        state_d      = WAIT_FILL;
      end
      WAIT_FILL: begin
        // A fill arriving with a cancel still commits.
        if (fill_valid) begin
          fill_fire = 1'b1;
          state_d   = IDLE;
        end else if (victim_cancel) begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request's set on accept and the chosen way on leaving PICK.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_set <= '0;
      pend_way <= '0;
    end else begin
      if (state_q == IDLE && victim_req) pend_set <= victim_set;
      if (state_q == PICK)               pend_way <= pick_way;
    end
  end

  // Per-set valid/MRU update; later statements override earlier ones on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      if (access_valid) mru_q[access_set]               <= access_way;
      if (fill_fire)    mru_q[pend_set]                 <= pend_way;
      if (inval_valid)  valid_q[inval_set][inval_way]   <= 1'b0;
      if (fill_fire)    valid_q[pend_set][pend_way]     <= 1'b1;
      if (inval_all) begin
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_victim_sel.sv
// Self-checking bench for cache_victim_sel: directed vector table, corner sequences, random vs model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requests only issued where the expected phase allows.
module tb_cache_victim_sel;
  import cache_victim_sel_pkg::*;

  localparam int NW = NUM_WAYS;
  localparam int NS = NUM_SETS;

  logic     clock = 1'b0;
  logic     reset;
  logic     access_valid, victim_req, victim_cancel, fill_valid, inval_valid, inval_all;
  set_idx_t access_set, victim_set, inval_set;
  way_idx_t access_way, inval_way, victim_way;
  logic     victim_ready, victim_valid;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cache_victim_sel #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clock         (clock),
    .reset         (reset),
    .access_valid  (access_valid),
    .access_set    (access_set),
    .access_way    (access_way),
    .victim_req    (victim_req),
    .victim_set    (victim_set),
    .victim_ready  (victim_ready),
    .victim_valid  (victim_valid),
    .victim_way    (victim_way),
    .victim_cancel (victim_cancel),
    .fill_valid    (fill_valid),
    .inval_valid   (inval_valid),
    .inval_set     (inval_set),
    .inval_way     (inval_way),
    .inval_all     (inval_all)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input int act, input int forbidden);
    total++;
    if (act == forbidden) begin
      bad++;
      $display("FAIL %s: got %0d expected anything but %0d", name, act, forbidden);
    end
  endtask

  task automatic clr_in();
    reset = 0; access_valid = 0; access_set = '0; access_way = '0;
    victim_req = 0; victim_set = '0; victim_cancel = 0; fill_valid = 0;
    inval_valid = 0; inval_set = '0; inval_way = '0; inval_all = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit req; int vset; bit cancel; bit fill;
    bit acc; int aset; int away; bit inv; int iset; int iway; bit iall;
    bit e_rdy; bit e_vld; int e_way;
  } vec_t;

  vec_t tbl[$];
  int   tbl_way;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic void add_idle(vec_t v);
    v.e_rdy = 1; v.e_vld = 0; v.e_way = tbl_way;
    tbl.push_back(v);
  endfunction

  function automatic void add_wait(vec_t v);
    v.e_rdy = 0; v.e_vld = 0; v.e_way = tbl_way;
    tbl.push_back(v);
    if (v.rst) tbl_way = 0;
  endfunction

  function automatic void add_pick(int s, int w, bit hold);
    vec_t v;
    v = blank(); v.req = 1; v.vset = s;
    add_idle(v);
    v = blank(); v.req = hold; v.vset = s;
    v.e_rdy = 0; v.e_vld = 1; v.e_way = w;
    tbl.push_back(v);
    tbl_way = w;
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    victim_req    = v.req;   victim_set = set_idx_t'(v.vset);
    victim_cancel = v.cancel; fill_valid = v.fill;
    access_valid  = v.acc;   access_set = set_idx_t'(v.aset); access_way = way_idx_t'(v.away);
    inval_valid   = v.inv;   inval_set  = set_idx_t'(v.iset); inval_way  = way_idx_t'(v.iway);
    inval_all     = v.iall;
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_valid [NS][NW];
  int m_mru   [NS];
  int m_ph;     // 0 waiting for request, 1 victim presented, 2 awaiting fill
  int m_pset, m_pway, m_last;
  bit seen [NW];

  task automatic model_step();
    bit fe;
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        m_mru[s] = 0;
        for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
      end
      m_ph = 0; m_last = 0;
    end else begin
      fe = (m_ph == 2) && fill_valid;
      if (access_valid) m_mru[access_set] = int'(access_way);
      if (fe)           m_mru[m_pset] = m_pway;
      if (inval_valid)  m_valid[inval_set][inval_way] = 0;
      if (fe)           m_valid[m_pset][m_pway] = 1;
      if (inval_all) begin
        for (int s = 0; s < NS; s++)
          for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
      end
      case (m_ph)
        0: if (victim_req) begin m_ph = 1; m_pset = int'(victim_set); end
        1: m_ph = 2;
        default: if (fill_valid || victim_cancel) m_ph = 0;
      endcase
    end
  endtask

  // Compare outputs against the model, advance the model, then clock the DUT.
  task automatic tick();
    int lo;
    chk("ready", int'(victim_ready), int'(m_ph == 0));
    chk("valid", int'(victim_valid), int'(m_ph == 1));
    if (m_ph == 1) begin
      lo = -1;
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[m_pset][w]) lo = w;
      if (lo >= 0) begin
        chk("pick_lowest_invalid", int'(victim_way), lo);
        m_pway = lo;
      end else begin
        chk_ne("pick_not_mru", int'(victim_way), m_mru[m_pset]);
        m_pway = int'(victim_way);
        seen[victim_way] = 1;
      end
      m_last = m_pway;
    end else begin
      chk("hold_way", int'(victim_way), m_last);
    end
    model_step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    clr_in(); reset = 1; tick(); clr_in();
  endtask

  // One request/pick/wait exchange; kind 0 commits the fill, 1 cancels.
  task automatic pair(input int s, input int kind);
    clr_in(); victim_req = 1; victim_set = set_idx_t'(s); tick();
    clr_in(); tick();
    clr_in(); if (kind == 0) fill_valid = 1; else victim_cancel = 1; tick();
    clr_in();
  endtask

  initial begin
    vec_t v;
    clr_in();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    // Table: cold fills, invalidation, cancel/busy, collisions, reset mid-fill.
    tbl_way = 0;
    for (int k = 0; k < 4; k++) begin add_pick(3, k, 0); v = blank(); v.fill = 1; add_wait(v); end
    for (int k = 0; k < 4; k++) begin add_pick(5, k, 0); v = blank(); v.fill = 1; add_wait(v); end
    v = blank(); v.inv = 1; v.iset = 5; v.iway = 1; add_idle(v);
    add_pick(5, 1, 0); v = blank(); v.fill = 1; add_wait(v);
    v = blank(); v.iall = 1; add_idle(v);
    add_pick(5, 0, 0); v = blank(); v.cancel = 1; add_wait(v);
    add_idle(blank());
    add_pick(5, 0, 1); v = blank(); v.req = 1; v.vset = 5; v.fill = 1; add_wait(v);
    add_idle(blank());
    add_pick(5, 1, 0); v = blank(); v.fill = 1; add_wait(v);
    add_pick(5, 2, 0);
    v = blank(); v.fill = 1; v.acc = 1; v.aset = 5; v.away = 0;
    v.inv = 1; v.iset = 5; v.iway = 2; add_wait(v);
    add_pick(5, 3, 0); v = blank(); v.cancel = 1; add_wait(v);
    add_pick(7, 0, 0); v = blank(); v.rst = 1; v.fill = 1; add_wait(v);
    add_idle(blank());
    add_pick(3, 0, 0); v = blank(); v.cancel = 1; add_wait(v);
    add_pick(5, 0, 0); v = blank(); v.cancel = 1; add_wait(v);
    add_idle(blank());

    foreach (tbl[i]) begin
      drive(tbl[i]);
      chk($sformatf("vec%0d ready", i), int'(victim_ready), int'(tbl[i].e_rdy));
      chk($sformatf("vec%0d valid", i), int'(victim_valid), int'(tbl[i].e_vld));
      chk($sformatf("vec%0d way", i),   int'(victim_way),   tbl[i].e_way);
      @(posedge clock); #1;
    end

    // Full set rotation: set 3 filled, MRU moved to 2, then 32 replacements.
    do_reset();
    for (int k = 0; k < 4; k++) pair(3, 0);
    clr_in(); access_valid = 1; access_set = 3; access_way = 2; tick(); clr_in();
    for (int w = 0; w < NW; w++) seen[w] = 0;
    for (int k = 0; k < 32; k++) pair(3, 0);
    for (int w = 0; w < NW; w++) chk($sformatf("nmru_cover_way%0d", w), int'(seen[w]), 1);

    // Fill of pend_way 2 racing an access to way 0: MRU must end at 2.
    do_reset();
    for (int k = 0; k < 4; k++) pair(6, 0);
    clr_in(); inval_valid = 1; inval_set = 6; inval_way = 2; tick();
    clr_in(); victim_req = 1; victim_set = 6; tick();
    clr_in(); tick();
    clr_in(); fill_valid = 1; access_valid = 1; access_set = 6; access_way = 0; tick();
    clr_in();
    for (int k = 0; k < 8; k++) pair(6, 1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      clr_in();
      reset         = ($urandom_range(0, 499) == 0);
      victim_req    = ($urandom_range(0, 99) < 50);
      victim_set    = set_idx_t'($urandom_range(0, 3));
      fill_valid    = ($urandom_range(0, 99) < 30);
      victim_cancel = ($urandom_range(0, 99) < 15);
      access_valid  = ($urandom_range(0, 99) < 30);
      access_set    = set_idx_t'($urandom_range(0, 3));
      access_way    = way_idx_t'($urandom_range(0, NW - 1));
      inval_valid   = ($urandom_range(0, 99) < 10);
      inval_set     = set_idx_t'($urandom_range(0, 3));
      inval_way     = way_idx_t'($urandom_range(0, NW - 1));
      inval_all     = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
